// File: rtl/tpu_pkg.sv
// Shared definitions for the MAC skew feeder: default geometry, FSM state
// type and the width used by the row counter and the stream counter.
package tpu_pkg;

  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF     = 8;
  localparam int CNT_W_DEF   = $clog2(2 * DIM_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE
  } state_t;

  // Counter width for a given tile dimension; it must hold both DIM (row
  // count) and 2*DIM-2 (last stream cycle).
  function automatic int cnt_w(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/mac_skew_feeder_if.sv
// Tile-load / stream bus of the MAC skew feeder.
// Optional err output is present only with MAC_SKEW_FEEDER_ERR_EN defined.
interface mac_skew_feeder_if
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
);

  logic                              WrEn;
  logic signed [DIM-1:0][BITS_AB-1:0] Arow;
  logic                              start;
  logic                              en;
  logic signed [DIM-1:0][BITS_AB-1:0] Aout;
  logic                              full;
  logic                              busy;
  logic                              done;
`ifdef MAC_SKEW_FEEDER_ERR_EN
  logic                              err;
`endif

  // Feeder side
  modport slave (
    input  WrEn, Arow, start,
`ifdef MAC_SKEW_FEEDER_ERR_EN
    output err,
`endif
    output en, Aout, full, busy, done
  );

  // Controller side
  modport master (
    output WrEn, Arow, start,
`ifdef MAC_SKEW_FEEDER_ERR_EN
    input  err,
`endif
    input  en, Aout, full, busy, done
  );

endinterface

// File: rtl/skew_lane.sv
// One lane of the skew feeder: stores a tile row and, while streaming,
// presents element t-LANE (zero outside the row) so lane LANE is delayed by
// LANE cycles relative to lane 0.
module skew_lane
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF,
  parameter int LANE    = 0,
  parameter int CW      = CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               we_i,
  input  logic signed [DIM-1:0][BITS_AB-1:0] wdata_i,
  input  logic                               stream_i,
  input  logic [CW-1:0]                      t_i,
  output logic signed [BITS_AB-1:0]          lane_o
);

  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  logic signed [DIM-1:0][BITS_AB-1:0] row_q;
  logic [CW:0]                        col;

  // Row storage; contents are only observable after a fresh write.
  always_ff @(posedge clk) begin
    if (we_i) row_q <= wdata_i;
  end

  // Column select t-LANE with zero fill before and after the row.
  always_comb begin
    lane_o = '0;
    col    = {1'b0, t_i} - (CW + 1)'(LANE);
    if (stream_i && ({1'b0, t_i} >= (CW + 1)'(LANE)) && (col < (CW + 1)'(DIM)))
      lane_o = row_q[col[IW-1:0]];
  end

endmodule

// File: rtl/mac_skew_feeder.sv
// MAC skew feeder: collects DIM rows of A, then streams them diagonally
// (lane i delayed by i cycles) over 2*DIM-1 cycles with en high.
// Optional sticky err output enabled by MAC_SKEW_FEEDER_ERR_EN.
module mac_skew_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM     = DIM_DEF
) (
  input logic              clk,
  input logic              rst,
  mac_skew_feeder_if.slave bus
);

  localparam int            CW     = cnt_w(DIM);
  localparam logic [CW-1:0] DIM_C  = CW'(DIM);
  localparam logic [CW-1:0] LAST_T = CW'(2 * DIM - 2);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] t_q, t_d;
  logic          full_q, full_d;
  logic          wr_ok, start_ok, stream;

  logic signed [DIM-1:0][BITS_AB-1:0] aout;

  // A write lands only while collecting and not yet full; start only once
  // the tile was already full before this cycle's write.
  assign wr_ok    = bus.WrEn && ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && (cnt_q < DIM_C);
  assign start_ok = bus.start && (state_q == ST_LOAD) && full_q;
  assign stream   = (state_q == ST_STREAM);

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      full_q  <= full_d;
    end
  end

  // Next-state: load rows, stream 2*DIM-1 cycles, one DONE cycle, back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (start_ok) begin
          state_d = ST_STREAM;
          t_d     = '0;
        end else if (wr_ok) begin
          state_d = ST_LOAD;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_STREAM: begin
        t_d = t_q + 1'b1;
        if (t_q == LAST_T) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        t_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    full_d = (cnt_d == DIM_C);
  end

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    skew_lane #(
      .BITS_AB(BITS_AB),
      .DIM    (DIM),
      .LANE   (i),
      .CW     (CW)
    ) u_lane (
      .clk     (clk),
      .we_i    (wr_ok && (cnt_q == CW'(i))),
      .wdata_i (bus.Arow),
      .stream_i(stream),
      .t_i     (t_q),
      .lane_o  (aout[i])
    );
  end

  assign bus.Aout = aout;
  assign bus.en   = stream;
  assign bus.busy = stream;
  assign bus.done = (state_q == ST_DONE);
  assign bus.full = full_q;

`ifdef MAC_SKEW_FEEDER_ERR_EN
  logic err_q;
  logic ign_wr, ign_start;

  assign ign_wr    = bus.WrEn && !wr_ok;
  assign ign_start = bus.start && ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !start_ok;

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | ign_wr | ign_start;
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Directed + randomized bench for mac_skew_feeder (DIM=4, BITS_AB=8).
module tb_mac_skew_feeder;

  localparam int DIM     = 4;
  localparam int BITS_AB = 8;
  localparam int ROW_W   = DIM * BITS_AB;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference tile and row count as the block should hold them.
  logic [BITS_AB-1:0] tile [DIM][DIM];
  int                 m_cnt = 0;

  always #5 clk = ~clk;

  mac_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

  mac_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".en"},   32'(bus.en),   32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd0);
    for (int i = 0; i < DIM; i++)
      check($sformatf("%s.lane%0d", tag, i), 32'(bus.Aout[i]), 32'd0);
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int j = 0; j < DIM; j++) r[j*BITS_AB +: BITS_AB] = BITS_AB'($urandom);
    return r;
  endfunction

  // Present one row; the model keeps it only while fewer than DIM rows are held.
  task automatic wr(input logic [ROW_W-1:0] row, input logic with_start);
    bus.Arow  = row;
    bus.WrEn  = 1'b1;
    bus.start = with_start;
    tick();
    bus.WrEn  = 1'b0;
    bus.start = 1'b0;
    if (m_cnt < DIM) begin
      for (int j = 0; j < DIM; j++) tile[m_cnt][j] = row[j*BITS_AB +: BITS_AB];
      m_cnt++;
    end
  endtask

  task automatic load_random();
    for (int r = 0; r < DIM; r++) wr(rand_row(), 1'b0);
  endtask

  // Start, then compare every stream cycle against the diagonal of the tile.
  task automatic run_stream(input string tag);
    logic [BITS_AB-1:0] e;
    int c;
    check({tag, ".full_pre"}, 32'(bus.full), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t <= 2 * DIM - 2; t++) begin
      check($sformatf("%s.t%0d.en", tag, t),   32'(bus.en),   32'd1);
      check($sformatf("%s.t%0d.busy", tag, t), 32'(bus.busy), 32'd1);
      check($sformatf("%s.t%0d.done", tag, t), 32'(bus.done), 32'd0);
      for (int i = 0; i < DIM; i++) begin
        c = t - i;
        e = (c >= 0 && c < DIM) ? tile[i][c] : '0;
        check($sformatf("%s.t%0d.lane%0d", tag, t, i), 32'(bus.Aout[i]), 32'(e));
      end
      tick();
    end
    check({tag, ".done"},    32'(bus.done), 32'd1);
    check({tag, ".done_en"}, 32'(bus.en),   32'd0);
    check({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
    tick();
    m_cnt = 0;
    check_quiet({tag, ".idle"});
    check({tag, ".full_post"}, 32'(bus.full), 32'd0);
  endtask

  initial begin
    logic [ROW_W-1:0] row;

    rst       = 1'b1;
    bus.WrEn  = 1'b0;
    bus.start = 1'b0;
    bus.Arow  = '0;
    tick();
    tick();
    check_quiet("reset");
    check("reset.full", 32'(bus.full), 32'd0);
`ifdef MAC_SKEW_FEEDER_ERR_EN
    check("reset.err", 32'(bus.err), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Tile A[i][j] = 10*i + j
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) row[j*BITS_AB +: BITS_AB] = BITS_AB'(10 * i + j);
      wr(row, 1'b0);
      check($sformatf("s1.full_row%0d", i), 32'(bus.full), 32'(i == DIM - 1));
    end
    run_stream("s1");
`ifdef MAC_SKEW_FEEDER_ERR_EN
    check("s1.err", 32'(bus.err), 32'd0);
`endif

    // Start after only three rows is ignored
    for (int r = 0; r < DIM - 1; r++) wr(rand_row(), 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s2.busy", 32'(bus.busy), 32'd0);
    check("s2.en",   32'(bus.en),   32'd0);
    tick();
    check("s2.busy2", 32'(bus.busy), 32'd0);
`ifdef MAC_SKEW_FEEDER_ERR_EN
    check("s2.err", 32'(bus.err), 32'd1);
`endif

    // Fourth row together with start: the write wins, start is ignored
    wr(rand_row(), 1'b1);
    check("s3.same_cycle_busy", 32'(bus.busy), 32'd0);
    check("s3.same_cycle_full", 32'(bus.full), 32'd1);

    // Fifth write of 0x7F is dropped
    wr({DIM{8'h7F}}, 1'b0);
    check("s3.fifth_full", 32'(bus.full), 32'd1);
    check("s3.fifth_busy", 32'(bus.busy), 32'd0);
    run_stream("s3");
`ifdef MAC_SKEW_FEEDER_ERR_EN
    check("s3.err_sticky", 32'(bus.err), 32'd1);
`endif

    // Reset at stream cycle 3
    load_random();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("s4.busy_t3", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_cnt = 0;
    check_quiet("s4.after_rst");
    check("s4.full", 32'(bus.full), 32'd0);
`ifdef MAC_SKEW_FEEDER_ERR_EN
    check("s4.err", 32'(bus.err), 32'd0);
`endif
    for (int k = 0; k < 2 * DIM; k++) begin
      tick();
      check($sformatf("s4.no_done%0d", k), 32'(bus.done), 32'd0);
      check($sformatf("s4.no_en%0d", k),   32'(bus.en),   32'd0);
    end

    // Most negative value passes through untouched
    for (int r = 0; r < DIM; r++) wr({DIM{8'h80}}, 1'b0);
    run_stream("s5");

    // Two back-to-back random tiles
    load_random();
    run_stream("s6a");
    load_random();
    run_stream("s6b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_skew_feeder.md
MAC_SKEW_FEEDER -- requirements
Module: mac_skew_feeder

Interface
REQ-001 The block SHALL have parameter BITS_AB, default 8: element width in bits, matching the MAC A/B operand width.
REQ-002 The block SHALL have parameter DIM, default 8: number of lanes and number of rows per tile; legal values are 2 to 16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port WrEn, input, 1 bit: writes Arow as the next tile row.
REQ-006 The block SHALL have port Arow, input, DIM x BITS_AB signed: the row being written; element j is column j.
REQ-007 The block SHALL have port start, input, 1 bit: begins streaming a full tile.
REQ-008 The block SHALL have port en, output, 1 bit: MAC-array enable, high during stream cycles.
REQ-009 The block SHALL have port Aout, output, DIM x BITS_AB signed: skewed lane data; lane i drives array row i.
REQ-010 The block SHALL have port full, output, 1 bit: high when DIM rows are loaded.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in the STREAM state.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last stream cycle.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, STREAM and DONE; the state after reset is IDLE.
REQ-014 In IDLE or LOAD, WrEn with row count below DIM SHALL store Arow at row index = count, increment count, and enter LOAD.
REQ-015 WrEn SHALL be ignored when full=1 or in STREAM or DONE; the tile contents and the count stay unchanged.
REQ-016 full SHALL equal (count == DIM), registered, so it is valid the cycle after the DIM-th write.
REQ-017 start SHALL be accepted only in LOAD with full=1; otherwise it is ignored.
REQ-018 If WrEn and start occur in the same cycle, the write SHALL be evaluated first; start is accepted only if full was already 1.
REQ-019 Accepting start SHALL enter STREAM on the next edge and clear the stream counter t to 0.
REQ-020 In STREAM cycle t, for t = 0 to 2*DIM-2, en SHALL be 1.
REQ-021 In STREAM cycle t, Aout lane i SHALL be A[i][t-i] when 0 <= t-i < DIM, and 0 otherwise.
REQ-022 After cycle t = 2*DIM-2, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE with count=0.
REQ-023 Outside STREAM, en SHALL be 0 and every Aout lane SHALL be 0.
REQ-024 busy SHALL be 1 exactly when the state is STREAM.
REQ-025 Latency SHALL be: start accepted at edge k gives the first en=1 in the cycle after edge k, and done=1 at cycle k+2*DIM.
REQ-026 Data SHALL pass through unmodified, with no arithmetic; the zero fill is signed 0.

Reset
REQ-027 rst=1 SHALL force, at the next edge: state IDLE, count 0, t 0, en 0, Aout all 0, full 0, busy 0, done 0.
REQ-028 rst in mid-STREAM SHALL abort the stream; the tile is discarded and no done pulse is issued.
REQ-029 Tile storage contents need not be cleared by reset, since they are unobservable until rewritten.

Configuration
REQ-030 With macro MAC_SKEW_FEEDER_ERR_EN defined, the block SHALL add output err (1 bit), which is set sticky by an ignored WrEn (REQ-015) or an ignored start in IDLE or LOAD.
REQ-031 With MAC_SKEW_FEEDER_ERR_EN defined, err SHALL be cleared only by rst.
REQ-032 Without MAC_SKEW_FEEDER_ERR_EN, the err port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-033 Shared package tpu_pkg SHALL hold the BITS_AB and DIM defaults, the state enum type, and the count/t width constant ($clog2(2*DIM)).
REQ-034 One sub-module, skew_lane, SHALL be instantiated DIM times: it holds one row and applies the zero-padded delay of i cycles for lane i.

Verification (bench uses DIM=4, BITS_AB=8)
REQ-035 Load rows A[i][j] = 10*i+j, then start -> en high for 7 cycles; lane0 gives 0,1,2,3,0,0,0; lane3 gives 0,0,0,30,31,32,33; then done for one cycle.
REQ-036 start after only 3 writes -> busy stays 0 and en stays 0; with ERR_EN defined, err=1.
REQ-037 5th WrEn with Arow all 0x7F after 4 writes -> ignored; the streamed data still matches the first 4 rows.
REQ-038 rst asserted at stream cycle 3 -> the next cycle has en=0, Aout=0, done never pulses, full=0.
REQ-039 Load A[i][j] = -128 (0x80) -> Aout lanes carry 0x80 unchanged, with no sign corruption.
REQ-040 Two back-to-back tiles (reload during IDLE after done) -> the second stream matches the second tile with no residue from the first.
